regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with a pending (scoreboard) bit per register.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.

module regfile_mp_rd #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int NWR   = 4,
  parameter int AW    = $clog2(DEPTH)
) (
`ifdef REGFILE_BYPASS_EN
  input  logic [NWR-1:0]            wr_en,
  input  logic [NWR-1:0][AW-1:0]    wr_addr,
  input  logic [NWR-1:0][WIDTH-1:0] wr_data,
  input  logic                      alloc_en,
  input  logic [AW-1:0]             alloc_addr,
`endif
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]          pending,
  input  logic [AW-1:0]             rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_ready
);
  always_comb begin
    rd_data  = mem[rd_addr];
    rd_ready = ~pending[rd_addr];
`ifdef REGFILE_BYPASS_EN
    // Descending scan so the lowest-numbered matching port is applied last.
    for (int k = NWR-1; k >= 0; k--) begin
      if (wr_en[k] && wr_addr[k] == rd_addr) begin
        rd_data  = wr_data[k];
        rd_ready = ~(alloc_en && alloc_addr == rd_addr);
      end
    end
`endif
    if (rd_addr == '0) begin
      rd_data  = '0;
      rd_ready = 1'b1;
    end
  end
endmodule

module regfile_mp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int NRD   = 2,
  parameter int NWR   = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_ready,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic [AW:0]          pend_cnt
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            pending, pend_nxt;
  logic [NWR-1:0][AW-1:0]      wa;
  logic [NWR-1:0][WIDTH-1:0]   wd;
  logic [NRD-1:0][AW-1:0]      ra;
  logic [NRD-1:0][WIDTH-1:0]   rdv;

  assign wa      = wr_addr;
  assign wd      = wr_data;
  assign ra      = rd_addr;
  assign rd_data = rdv;

  // Writes clear pending first so a same-cycle alloc leaves the bit set.
  always_comb begin
    pend_nxt = pending;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k]) pend_nxt[wa[k]] = 1'b0;
    if (alloc_en) pend_nxt[alloc_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '0;
      pending <= '0;
    end else begin
      for (int k = NWR-1; k >= 0; k--)
        if (wr_en[k] && wa[k] != '0) mem[wa[k]] <= wd[k];
      pending <= pend_nxt;
    end
  end

  // Bit 0 is never set, so the count stays at or below DEPTH-1.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      pend_cnt = pend_cnt + (AW+1)'(pending[i]);
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    regfile_mp_rd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NWR(NWR), .AW(AW)) u_rd (
`ifdef REGFILE_BYPASS_EN
      .wr_en      (wr_en),
      .wr_addr    (wa),
      .wr_data    (wd),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
`endif
      .mem        (mem),
      .pending    (pending),
      .rd_addr    (ra[j]),
      .rd_data    (rdv[j]),
      .rd_ready   (rd_ready[j])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp; expected values are hand-derived.

module tb_regfile_mp;
  localparam int W = 16, D = 64, NRD = 2, NWR = 4, AW = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic [NWR-1:0]     wr_en;
  logic [NWR*AW-1:0]  wr_addr;
  logic [NWR*W-1:0]   wr_data;
  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD*W-1:0]   rd_data;
  logic [NRD-1:0]     rd_ready;
  logic               alloc_en;
  logic [AW-1:0]      alloc_addr;
  logic [AW:0]        pend_cnt;

  int checks = 0, errors = 0;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic wr(input int k, input int a, input logic [W-1:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*W +: W] = d;
  endtask

  task automatic alloc(input int a);
    alloc_en = 1'b1; alloc_addr = AW'(a);
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
    #1;
  endtask

  // Inputs change 1 ns after the rising edge; checks follow a further 1 ns.
  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    rst = 1'b1; idle(); rd_addr = '0;
    tick(); tick();
    rst = 1'b0;

    rd(5, 5);
    chk("rst_rd0", rd_data[0 +: W], 16'h0000);
    chk("rst_rd1", rd_data[W +: W], 16'h0000);
    chk("rst_rdy", rd_ready, 2'b11);
    chk("rst_cnt", pend_cnt, 0);

    wr(0, 3, 16'h1111); wr(2, 3, 16'h2222);
    tick(); rd(3, 0);
    chk("prio_r3", rd_data[0 +: W], 16'h1111);

    wr(0, 15, 16'h000A); wr(1, 15, 16'h000B); wr(2, 16, 16'h000C);
    tick(); rd(15, 16);
    chk("prio_r15", rd_data[0 +: W], 16'h000A);
    chk("prio_r16", rd_data[W +: W], 16'h000C);

    wr(0, 10, 16'h0A0A); wr(1, 11, 16'h0B0B); wr(2, 12, 16'h0C0C); wr(3, 13, 16'h0D0D);
    tick(); rd(10, 11);
    chk("all4_r10", rd_data[0 +: W], 16'h0A0A);
    chk("all4_r11", rd_data[W +: W], 16'h0B0B);
    rd(12, 13);
    chk("all4_r12", rd_data[0 +: W], 16'h0C0C);
    chk("all4_r13", rd_data[W +: W], 16'h0D0D);

    wr(1, 0, 16'hFFFF); alloc(0);
    tick(); rd(0, 0);
    chk("r0_data", rd_data[0 +: W], 16'h0000);
    chk("r0_rdy", rd_ready, 2'b11);
    chk("r0_cnt", pend_cnt, 0);

    alloc(7);
    tick(); rd(7, 0);
    chk("a7_cnt", pend_cnt, 1);
    chk("a7_rdy", rd_ready, 2'b10);
    wr(3, 7, 16'hABCD); rd(7, 0);
`ifdef REGFILE_BYPASS_EN
    chk("byp_r7", rd_data[0 +: W], 16'hABCD);
    chk("byp_rdy7", rd_ready[0], 1'b1);
`else
    chk("nobyp_r7", rd_data[0 +: W], 16'h0000);
    chk("nobyp_rdy7", rd_ready[0], 1'b0);
`endif
    tick(); rd(7, 0);
    chk("w7_cnt", pend_cnt, 0);
    chk("w7_data", rd_data[0 +: W], 16'hABCD);
    chk("w7_rdy", rd_ready[0], 1'b1);

    alloc(9); wr(0, 9, 16'h0042);
    tick(); rd(9, 0);
    chk("a9_data", rd_data[0 +: W], 16'h0042);
    chk("a9_rdy", rd_ready[0], 1'b0);
    chk("a9_cnt", pend_cnt, 1);

    wr(1, 20, 16'h2020); alloc(20); rd(20, 0);
`ifdef REGFILE_BYPASS_EN
    chk("byp_a20_data", rd_data[0 +: W], 16'h2020);
    chk("byp_a20_rdy", rd_ready[0], 1'b0);
`else
    chk("nobyp_a20_data", rd_data[0 +: W], 16'h0000);
    chk("nobyp_a20_rdy", rd_ready[0], 1'b1);
`endif
    tick(); rd(20, 0);
    chk("a20_data", rd_data[0 +: W], 16'h2020);
    chk("a20_cnt", pend_cnt, 2);

    alloc(1); tick();
    alloc(2); tick();
    alloc(3); tick();
    rd(1, 3);
    chk("a123_cnt", pend_cnt, 5);
    chk("a123_rdy", rd_ready, 2'b00);

    rst = 1'b1; wr(0, 4, 16'h5555); alloc(5);
    tick(); rst = 1'b0; rd(4, 3);
    chk("rst2_cnt", pend_cnt, 0);
    chk("rst2_r4", rd_data[0 +: W], 16'h0000);
    chk("rst2_r3", rd_data[W +: W], 16'h0000);
    chk("rst2_rdy", rd_ready, 2'b11);
    rd(5, 9);
    chk("rst2_rdy59", rd_ready, 2'b11);

    wr(2, 4, 16'h4444);
    tick(); rd(4, 0);
    chk("resume_r4", rd_data[0 +: W], 16'h4444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
